// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Decode-stage hazard unit for a 5-stage (F D E M W) pipeline. It keeps one
// slot per in-flight writer stage (E, M, W). Each slot holds {valid, rd,
// is_load}. From these slots it derives a combinational stall request and the
// operand bypass selects that travel into E with the decode instruction.
//
// Register 0 is hard-wired zero, so it never creates a dependency. A writer
// with rd=0 enters E as a bubble, and a source index of 0 never matches a slot.
//
// Configuration macro: HAZARD_SCOREBOARD_FORWARDING_EN
//   defined   : bypass network present. A consumer stalls only on an E-stage
//               match or on a load in M. Selects name the M or W bypass.
//   undefined : no bypass network. Any match in E, M or W stalls, and both
//               selects stay at 00 (register file).
//
// Ports
//   clk            pipeline clock
//   reset          synchronous, active-high reset
//   dec_valid      decode stage holds a real instruction
//   dec_rs1/_used  source register 1 index / instruction reads it
//   dec_rs2/_used  source register 2 index / instruction reads it
//   dec_rd         destination register index
//   dec_writes_rd  instruction writes dec_rd
//   dec_is_load    instruction is a load (result available only after M)
//   freeze         whole-pipeline hold; all state holds
//   flush          kill the decode instruction
//   stall          hold F/D and inject a bubble into E (combinational)
//   fwd_rs1_sel    operand select for the instruction in E:
//                  00 regfile, 01 from M, 10 from W
//   fwd_rs2_sel    same encoding, for rs2
//   stall_count    number of cycles with stall=1 and freeze=0 (wraps)
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int COUNTER_WIDTH  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      dec_valid,
    input  logic [REG_ADDR_WIDTH-1:0] dec_rs1,
    input  logic                      dec_rs1_used,
    input  logic [REG_ADDR_WIDTH-1:0] dec_rs2,
    input  logic                      dec_rs2_used,
    input  logic [REG_ADDR_WIDTH-1:0] dec_rd,
    input  logic                      dec_writes_rd,
    input  logic                      dec_is_load,
    input  logic                      freeze,
    input  logic                      flush,
    output logic                      stall,
    output logic [1:0]                fwd_rs1_sel,
    output logic [1:0]                fwd_rs2_sel,
    output logic [COUNTER_WIDTH-1:0]  stall_count
);

    localparam logic [1:0] SEL_REGFILE = 2'b00;
`ifdef HAZARD_SCOREBOARD_FORWARDING_EN
    localparam logic [1:0] SEL_MEM     = 2'b01;
    localparam logic [1:0] SEL_WB      = 2'b10;
`endif

    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO  = '0;
    localparam logic [COUNTER_WIDTH-1:0]  COUNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      is_load;
    } slot_t;

    localparam slot_t BUBBLE = '0;

    slot_t slot_e, slot_m, slot_w;
    slot_t dec_entry;

    logic rs1_e, rs1_m, rs1_w;
    logic rs2_e, rs2_m, rs2_w;
    logic raw_hazard;
    logic enter_e;
    logic [1:0] sel1_next, sel2_next;

    // A source depends on a slot only if the slot holds a live writer, the
    // instruction actually reads that source, and the index is not r0.
    function automatic logic src_match(
        input slot_t                      s,
        input logic                       used,
        input logic [REG_ADDR_WIDTH-1:0]  idx
    );
        return s.valid && used && (idx == s.rd) && (idx != REG_ZERO);
    endfunction

    assign rs1_e = src_match(slot_e, dec_rs1_used, dec_rs1);
    assign rs1_m = src_match(slot_m, dec_rs1_used, dec_rs1);
    assign rs1_w = src_match(slot_w, dec_rs1_used, dec_rs1);
    assign rs2_e = src_match(slot_e, dec_rs2_used, dec_rs2);
    assign rs2_m = src_match(slot_m, dec_rs2_used, dec_rs2);
    assign rs2_w = src_match(slot_w, dec_rs2_used, dec_rs2);

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
        raw_hazard = 1'b0;
        sel1_next  = SEL_REGFILE;
        sel2_next  = SEL_REGFILE;
`ifdef HAZARD_SCOREBOARD_FORWARDING_EN
        // An ALU result in E is not ready yet. A load result in M is not
        // ready yet. Everything older can be bypassed.
        raw_hazard = rs1_e | rs2_e | ((rs1_m | rs2_m) & slot_m.is_load);
        // M is checked first because it holds the youngest writer, and its value supersedes W.
        if (rs1_m && !slot_m.is_load) begin
            sel1_next = SEL_MEM;
        end else if (rs1_w) begin
            sel1_next = SEL_WB;
        end
        if (rs2_m && !slot_m.is_load) begin
            sel2_next = SEL_MEM;
        end else if (rs2_w) begin
            sel2_next = SEL_WB;
        end
`else
        // Without bypass paths, a consumer waits until its producer has
        // written the register file.
        raw_hazard = rs1_e | rs1_m | rs1_w | rs2_e | rs2_m | rs2_w;
`endif
    end

    // flush kills the decode instruction, so a stall is pointless and flush overrides it.
    assign stall   = dec_valid & ~flush & raw_hazard;
    assign enter_e = dec_valid & ~stall & ~flush & dec_writes_rd & (dec_rd != REG_ZERO);

    assign dec_entry = '{valid: 1'b1, rd: dec_rd, is_load: dec_is_load};

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
        if (reset) begin
            slot_e      <= BUBBLE;
            slot_m      <= BUBBLE;
            slot_w      <= BUBBLE;
            fwd_rs1_sel <= SEL_REGFILE;
            fwd_rs2_sel <= SEL_REGFILE;
            stall_count <= '0;
        end else if (!freeze) begin
            slot_w <= slot_m;
            slot_m <= slot_e;
            slot_e <= enter_e ? dec_entry : BUBBLE;
            // The selects belong to the instruction leaving decode. During a
            // stall that instruction stays in D, so the selects hold.
            if (!stall) begin
                fwd_rs1_sel <= sel1_next;
                fwd_rs2_sel <= sel2_next;
            end else begin
                stall_count <= stall_count + COUNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Self-checking bench for hazard_scoreboard. The reference model keeps the
// in-flight writers as an age-indexed list (age 1 = youngest, 3 = oldest).
// Each source waits for its youngest in-flight producer until that result is
// ready:
//   - with bypass: an ALU result is ready at age 2 and a load at age 3;
//   - without bypass: a result is ready only after it leaves the list.
// The model then compares stall, selects and counter every cycle. Directed
// instruction sequences cover the listed cases, followed by random traffic.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

`ifdef HAZARD_SCOREBOARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        dec_valid;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic        dec_rs1_used, dec_rs2_used, dec_writes_rd, dec_is_load;
    logic        freeze, flush;
    logic        stall;
    logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;
    logic [31:0] stall_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_ADDR_WIDTH(5), .COUNTER_WIDTH(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .dec_valid     (dec_valid),
        .dec_rs1       (dec_rs1),
        .dec_rs1_used  (dec_rs1_used),
        .dec_rs2       (dec_rs2),
        .dec_rs2_used  (dec_rs2_used),
        .dec_rd        (dec_rd),
        .dec_writes_rd (dec_writes_rd),
        .dec_is_load   (dec_is_load),
        .freeze        (freeze),
        .flush         (flush),
        .stall         (stall),
        .fwd_rs1_sel   (fwd_rs1_sel),
        .fwd_rs2_sel   (fwd_rs2_sel),
        .stall_count   (stall_count)
    );

    // ---------------- reference model ----------------
    logic        w_live [1:3];
    logic [4:0]  w_rd   [1:3];
    logic        w_load [1:3];
    logic [1:0]  m_sel1, m_sel2;
    logic [31:0] m_cnt;
    logic        seen_stall;

    function automatic logic writes_reg(input int age, input logic used, input logic [4:0] idx);
        return w_live[age] && used && idx != 5'd0 && w_rd[age] == idx;
    endfunction

    // Age at which the producer's value can reach the consumer.
    function automatic int ready_age(input logic is_load);
        if (!FWD) return 4;
        return is_load ? 3 : 2;
    endfunction

    function automatic logic src_blocked(input logic used, input logic [4:0] idx);
        for (int age = 1; age <= 3; age++) begin
            if (writes_reg(age, used, idx)) return age < ready_age(w_load[age]);
        end
        return 1'b0;
    endfunction

    // Take the youngest writer whose result is already available.
    function automatic logic [1:0] src_sel(input logic used, input logic [4:0] idx);
        if (!FWD) return 2'b00;
        for (int age = 2; age <= 3; age++) begin
            if (writes_reg(age, used, idx) && age >= ready_age(w_load[age]))
                return (age == 2) ? 2'b01 : 2'b10;
        end
        return 2'b00;
    endfunction

    function automatic logic model_stall();
        return dec_valid && !flush &&
               (src_blocked(dec_rs1_used, dec_rs1) || src_blocked(dec_rs2_used, dec_rs2));
    endfunction

    task automatic model_reset();
        for (int a = 1; a <= 3; a++) begin
            w_live[a] = 1'b0; w_rd[a] = 5'd0; w_load[a] = 1'b0;
        end
        m_sel1 = 2'b00; m_sel2 = 2'b00; m_cnt = 32'd0;
    endtask

    task automatic model_clock();
        logic       st;
        logic [1:0] s1, s2;
        if (reset) begin
            model_reset();
        end else if (!freeze) begin
            st = model_stall();
            s1 = src_sel(dec_rs1_used, dec_rs1);
            s2 = src_sel(dec_rs2_used, dec_rs2);
            for (int a = 3; a >= 2; a--) begin
                w_live[a] = w_live[a-1]; w_rd[a] = w_rd[a-1]; w_load[a] = w_load[a-1];
            end
            w_live[1] = dec_valid && !st && !flush && dec_writes_rd && dec_rd != 5'd0;
            w_rd[1]   = dec_rd;
            w_load[1] = dec_is_load;
            if (st) m_cnt = m_cnt + 32'd1;
            else begin
                m_sel1 = s1; m_sel2 = s2;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Check at the negedge, then advance the model at the posedge. Inputs may
    // change 1 time unit after that edge.
    task automatic cycle();
        @(negedge clk);
        seen_stall = stall;
        check("stall",       {31'd0, stall}, {31'd0, model_stall()});
        check("fwd_rs1_sel", {30'd0, fwd_rs1_sel}, {30'd0, m_sel1});
        check("fwd_rs2_sel", {30'd0, fwd_rs2_sel}, {30'd0, m_sel2});
        check("stall_count", stall_count, m_cnt);
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic set_dec(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic rs2_used, input logic is_load);
        dec_valid = 1'b1; dec_rd = rd; dec_writes_rd = 1'b1; dec_is_load = is_load;
        dec_rs1 = rs1; dec_rs1_used = 1'b1; dec_rs2 = rs2; dec_rs2_used = rs2_used;
    endtask

    task automatic idle();
        dec_valid = 1'b0; dec_writes_rd = 1'b0; dec_is_load = 1'b0;
        dec_rs1_used = 1'b0; dec_rs2_used = 1'b0;
        dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_rd = 5'd0;
    endtask

    // Present an instruction until it leaves decode and return its stall cycles.
    task automatic issue(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic rs2_used, input logic is_load, output int stalls);
        int guard;
        set_dec(rd, rs1, rs2, rs2_used, is_load);
        stalls = 0;
        guard  = 0;
        do begin
            cycle();
            if (seen_stall) stalls++;
            guard++;
        end while (seen_stall && guard < 20);
        check("issue_bound", {31'd0, seen_stall}, 32'd0);
        idle();
    endtask

    task automatic do_reset();
        idle(); freeze = 1'b0; flush = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        idle(); freeze = 1'b0; flush = 1'b0; reset = 1'b1;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        do_reset();
        check("reset_count", stall_count, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);

        // r0 writers reading r0 never stall.
        for (int i = 0; i < 4; i++) begin
            issue(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, n);
            check("r0_stalls", n, 32'd0);
        end
        check("r0_count", stall_count, 32'd0);

        // ALU -> dependent.
        do_reset();
        issue(5'd2, 5'd1, 5'd1, 1'b1, 1'b0, n);
        issue(5'd3, 5'd2, 5'd2, 1'b1, 1'b0, n);
        check("alu_stalls", n, FWD ? 32'd1 : 32'd3);
        check("alu_sel1", {30'd0, fwd_rs1_sel}, FWD ? 32'd1 : 32'd0);
        check("alu_sel2", {30'd0, fwd_rs2_sel}, FWD ? 32'd1 : 32'd0);
        check("alu_count", stall_count, FWD ? 32'd1 : 32'd3);

        // Load -> dependent.
        do_reset();
        issue(5'd4, 5'd1, 5'd0, 1'b0, 1'b1, n);
        issue(5'd5, 5'd4, 5'd4, 1'b1, 1'b0, n);
        check("load_stalls", n, FWD ? 32'd2 : 32'd3);
        check("load_sel1", {30'd0, fwd_rs1_sel}, FWD ? 32'd2 : 32'd0);
        check("load_sel2", {30'd0, fwd_rs2_sel}, FWD ? 32'd2 : 32'd0);

        // Two writers of r2: M must win over W.
        do_reset();
        issue(5'd2, 5'd1, 5'd1, 1'b1, 1'b0, n);
        issue(5'd2, 5'd1, 5'd1, 1'b1, 1'b0, n);
        issue(5'd6, 5'd2, 5'd0, 1'b1, 1'b0, n);
        check("mw_stalls", n, FWD ? 32'd1 : 32'd3);
        check("mw_sel1", {30'd0, fwd_rs1_sel}, FWD ? 32'd1 : 32'd0);
        check("mw_sel2", {30'd0, fwd_rs2_sel}, 32'd0);

        // Freeze while an ALU hazard is pending.
        do_reset();
        issue(5'd2, 5'd1, 5'd1, 1'b1, 1'b0, n);
        set_dec(5'd3, 5'd2, 5'd2, 1'b1, 1'b0);
        freeze = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("freeze_stall", {31'd0, seen_stall}, 32'd1);
        end
        check("freeze_count", stall_count, 32'd0);
        freeze = 1'b0;
        issue(5'd3, 5'd2, 5'd2, 1'b1, 1'b0, n);
        check("freeze_release", n, FWD ? 32'd1 : 32'd3);
        check("freeze_count2", stall_count, FWD ? 32'd1 : 32'd3);

        // Flush beats stall, and the killed writer leaves a bubble.
        do_reset();
        issue(5'd2, 5'd1, 5'd1, 1'b1, 1'b0, n);
        set_dec(5'd7, 5'd2, 5'd2, 1'b1, 1'b0);
        flush = 1'b1;
        cycle();
        check("flush_stall", {31'd0, seen_stall}, 32'd0);
        flush = 1'b0;
        issue(5'd8, 5'd7, 5'd7, 1'b1, 1'b0, n);
        check("flush_bubble", n, 32'd0);

        // Reset asserted while stalled.
        do_reset();
        issue(5'd2, 5'd1, 5'd1, 1'b1, 1'b0, n);
        set_dec(5'd3, 5'd2, 5'd2, 1'b1, 1'b0);
        reset = 1'b1;
        cycle();
        check("rst_pre_stall", {31'd0, seen_stall}, 32'd1);
        reset = 1'b0;
        cycle();
        check("rst_post_stall", {31'd0, seen_stall}, 32'd0);
        check("rst_post_count", stall_count, 32'd0);

        // Random traffic against the model.
        idle();
        for (int i = 0; i < 600; i++) begin
            reset         = ($urandom_range(0, 59) == 0);
            freeze        = ($urandom_range(0, 7) == 0);
            flush         = ($urandom_range(0, 9) == 0);
            dec_valid     = ($urandom_range(0, 4) != 0);
            dec_rd        = 5'($urandom_range(0, 3));
            dec_rs1       = 5'($urandom_range(0, 3));
            dec_rs2       = 5'($urandom_range(0, 3));
            dec_rs1_used  = ($urandom_range(0, 3) != 0);
            dec_rs2_used  = ($urandom_range(0, 1) != 0);
            dec_writes_rd = ($urandom_range(0, 4) != 0);
            dec_is_load   = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
